scie_issue_arbiter: RTL
=======================

# scie_issue_arbiter

Shares one fixed-latency SCIE custom-instruction unit between two requesters (e.g. two hart issue queues). Round-robin arbitrates valid/ready instruction requests onto the unit's single-cycle issue port. Tracks in-flight ops with a tag pipeline and steers each result into a per-requester held response register. Optionally locks the unit to one requester between its configure (0x2B) and compute (0x5B) ops so coefficient state is never clobbered.

## Interface
- LATENCY, 1, cycles from `scie_valid` high to the matching `scie_rd_*` being valid; must be ≥1.
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- reqN_valid  in  1  request N (N∈{0,1}) presents an instruction.
- reqN_ready  out  1  request N accepted this cycle (combinational from registered state and reqN_valid/reqN_insn).
- reqN_insn  in  32  instruction word; class from bits [6:0].
- reqN_rs1_real, reqN_rs1_imag  in  16 each  signed complex operand.
- reqN_rs2  in  32  second operand.
- respN_valid  out  1  result held for requester N.
- respN_ready  in  1  requester N consumes result.
- respN_real, respN_imag  out  16 each  signed result.
- scie_valid  out  1  registered issue strobe to the unit.
- scie_insn  out  32; scie_rs1_real, scie_rs1_imag  out  16 each; scie_rs2  out  32  registered payload.
- scie_rd_real, scie_rd_imag  in  16 each  unit result.
- err_illegal  out  1  sticky: an illegal opcode was accepted.

## Operation
- Opcode classes: 0x0B = compute, result; 0x2B = configure, no result; 0x5B = compute-with-config, result. Any other = illegal.
- Illegal: accepted when granted, not issued, sets `err_illegal` (cleared only by reset).
- outstanding[N] = in-flight result op for N in the tag pipe, or respN_valid. It is a registered value.
- Eligible(N): reqN_valid. If the op is result-producing, outstanding[N]=0. If the lock is held by the other requester, N is not eligible.
- Grant: at most one per cycle. If both requesters are eligible, the requester pointed to by `rr_ptr` wins. `rr_ptr` moves to the other requester after every grant. `rr_ptr` resets to 0.
- Granted non-illegal op: the payload is registered to scie_*, and `scie_valid`=1 next cycle. `scie_valid`=0 in cycles with no grant. The payload holds its last value.
- Tag pipe: LATENCY stages of {valid, id, has_result}, advanced every cycle. At its tail with valid & has_result, `scie_rd_*` is captured into respID and respID_valid is set.
- respN_valid is cleared on respN_valid & respN_ready. outstanding drops the following cycle, so a result-producing op from N is not granted in the same cycle as the handshake.
- Lock (see Configuration): a granted 0x2B with the lock free sets lock_owner=N and lock_held=1. A granted 0x5B from the owner clears lock_held. The owner's 0x0B and repeated 0x2B keep the lock.

## Timing
- Reset values: all reqN_ready=0 (while reset), respN_valid=0, respN_real/imag=0, scie_valid=0, all scie_* payload=0, err_illegal=0, lock_held=0, tag pipe empty, rr_ptr=0.
- Accept at cycle t gives scie_valid at t+1 and a result captured at the edge ending t+1+LATENCY. respN_valid is high from t+2+LATENCY.
- Maximum per-requester throughput: one result op per 3+LATENCY cycles when the response is consumed immediately. Configure ops issue back-to-back.
- Both requesters alternate every cycle when continuously eligible.
- Reset mid-operation discards in-flight results, clears the lock and clears the response registers. The unit's internal state is not touched.
- The response register never overflows; the outstanding rule guarantees this.

## Configuration
- SCIE_ARB_LOCK_EN defined: the ownership lock is active as described.
- SCIE_ARB_LOCK_EN undefined: lock logic is absent. Eligibility ignores ownership, giving pure round-robin, and configure/compute from different requesters may interleave.

## Test plan
- Stub unit returns rd = issued rs1 after LATENCY=1. req0 0x0B rs1=(-88,-452) at t → scie_valid at t+1; resp0=(-88,-452) valid at t+3.
- Both requesters hold 0x2B continuously → grants alternate 0,1,0,1 starting with req0 after reset.
- Lock on: req0 0x2B (77,-645), then req1 0x0B while req0 idle → req1_ready stays 0. req0 0x5B → lock released; req1 is granted the following cycle. Lock off: req1 is granted immediately.
- resp0_ready held 0 with resp0=(541,224) pending, req0 0x5B valid → req0_ready stays 0. The cycle after resp0_ready=1 → req0 is granted.
- req1 insn=0x00000033 → accepted once, no scie_valid, err_illegal=1 until reset.
- Reset asserted the cycle after a 0x5B issue → no resp appears, lock_held=0, all outputs at reset values.

Source files
------------

// File: rtl/scie_issue_arbiter_if.sv
// Bus bundle between the SCIE issue arbiter, its two requesters and the shared SCIE unit.
// The master modport is the arbiter's view; slave is the environment (requesters + unit).
interface scie_issue_arbiter_if;
    logic               req0_valid;
    logic               req0_ready;
    logic        [31:0] req0_insn;
    logic signed [15:0] req0_rs1_real;
    logic signed [15:0] req0_rs1_imag;
    logic        [31:0] req0_rs2;

    logic               req1_valid;
    logic               req1_ready;
    logic        [31:0] req1_insn;
    logic signed [15:0] req1_rs1_real;
    logic signed [15:0] req1_rs1_imag;
    logic        [31:0] req1_rs2;

    logic               resp0_valid;
    logic               resp0_ready;
    logic signed [15:0] resp0_real;
    logic signed [15:0] resp0_imag;

    logic               resp1_valid;
    logic               resp1_ready;
    logic signed [15:0] resp1_real;
    logic signed [15:0] resp1_imag;

    logic               scie_valid;
    logic        [31:0] scie_insn;
    logic signed [15:0] scie_rs1_real;
    logic signed [15:0] scie_rs1_imag;
    logic        [31:0] scie_rs2;
    logic signed [15:0] scie_rd_real;
    logic signed [15:0] scie_rd_imag;

    logic               err_illegal;

    modport master (
        input  req0_valid, req0_insn, req0_rs1_real, req0_rs1_imag, req0_rs2,
        output req0_ready,
        input  req1_valid, req1_insn, req1_rs1_real, req1_rs1_imag, req1_rs2,
        output req1_ready,
        output resp0_valid, resp0_real, resp0_imag,
        input  resp0_ready,
        output resp1_valid, resp1_real, resp1_imag,
        input  resp1_ready,
        output scie_valid, scie_insn, scie_rs1_real, scie_rs1_imag, scie_rs2,
        input  scie_rd_real, scie_rd_imag,
        output err_illegal
    );

    modport slave (
        output req0_valid, req0_insn, req0_rs1_real, req0_rs1_imag, req0_rs2,
        input  req0_ready,
        output req1_valid, req1_insn, req1_rs1_real, req1_rs1_imag, req1_rs2,
        input  req1_ready,
        input  resp0_valid, resp0_real, resp0_imag,
        output resp0_ready,
        input  resp1_valid, resp1_real, resp1_imag,
        output resp1_ready,
        input  scie_valid, scie_insn, scie_rs1_real, scie_rs1_imag, scie_rs2,
        output scie_rd_real, scie_rd_imag,
        input  err_illegal
    );
endinterface

// File: rtl/scie_issue_arbiter.sv
// Round-robin sharing of one fixed-latency SCIE unit between two requesters, with result steering.
// Define SCIE_ARB_LOCK_EN to lock the unit to one requester between its configure and compute ops.
module scie_issue_arbiter #(
    parameter int unsigned LATENCY = 1
) (
    input logic                  clock,
    input logic                  reset,
    scie_issue_arbiter_if.master bus
);
    localparam int unsigned OPC_W = 7;
    localparam logic [OPC_W-1:0] OPC_COMPUTE = OPC_W'(7'h0B);
    localparam logic [OPC_W-1:0] OPC_CONFIG  = OPC_W'(7'h2B);
    localparam logic [OPC_W-1:0] OPC_CCFG    = OPC_W'(7'h5B);

    typedef enum logic [1:0] {
        CLS_COMPUTE,
        CLS_CONFIG,
        CLS_CCFG,
        CLS_ILLEGAL
    } op_class_e;

    function automatic op_class_e classify(input logic [31:0] insn);
        case (insn[OPC_W-1:0])
            OPC_COMPUTE: classify = CLS_COMPUTE;
            OPC_CONFIG:  classify = CLS_CONFIG;
            OPC_CCFG:    classify = CLS_CCFG;
            default:     classify = CLS_ILLEGAL;
        endcase
    endfunction

    // Registered state
    logic               rr_ptr;
    logic               scie_valid_q;
    logic        [31:0] scie_insn_q;
    logic signed [15:0] scie_rs1_real_q;
    logic signed [15:0] scie_rs1_imag_q;
    logic        [31:0] scie_rs2_q;
    logic               issue_id_q;
    logic               issue_res_q;
    logic [LATENCY-1:0] tag_valid;
    logic [LATENCY-1:0] tag_id;
    logic [LATENCY-1:0] tag_res;
    logic         [1:0] resp_valid_q;
    logic signed [15:0] resp0_real_q, resp0_imag_q;
    logic signed [15:0] resp1_real_q, resp1_imag_q;
    logic               err_illegal_q;

    // Combinational arbitration signals
    op_class_e          cls0, cls1, sel_cls;
    logic               res0, res1, sel_res;
    logic         [1:0] outstanding;
    logic         [1:0] locked_out;
    logic         [1:0] elig;
    logic         [1:0] grant;
    logic               granted;
    logic               grant_id;
    logic               issue;
    logic        [31:0] sel_insn;
    logic signed [15:0] sel_rs1_real, sel_rs1_imag;
    logic        [31:0] sel_rs2;

    // Tag pipe shift inputs and tail
    logic [LATENCY:0]   tag_valid_ext, tag_id_ext, tag_res_ext;
    logic               tail_hit, tail_id;

    assign tag_valid_ext = {tag_valid, scie_valid_q};
    assign tag_id_ext    = {tag_id, issue_id_q};
    assign tag_res_ext   = {tag_res, issue_res_q};
    assign tail_hit      = tag_valid[LATENCY-1] & tag_res[LATENCY-1];
    assign tail_id       = tag_id[LATENCY-1];

    // A result op is outstanding from issue register through tag pipe until its response is consumed
    assign outstanding[0] = resp_valid_q[0]
                          | (|(tag_valid & tag_res & ~tag_id))
                          | (scie_valid_q & issue_res_q & ~issue_id_q);
    assign outstanding[1] = resp_valid_q[1]
                          | (|(tag_valid & tag_res & tag_id))
                          | (scie_valid_q & issue_res_q & issue_id_q);

`ifdef SCIE_ARB_LOCK_EN
    logic lock_held;
    logic lock_owner;

    // Ownership of the unit's coefficient state between configure and compute-with-config
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_held  <= 1'b0;
            lock_owner <= 1'b0;
        end else if (granted) begin
            if (sel_cls == CLS_CONFIG && !lock_held) begin
                lock_held  <= 1'b1;
                lock_owner <= grant_id;
            end else if (sel_cls == CLS_CCFG && lock_held && lock_owner == grant_id) begin
                lock_held <= 1'b0;
            end
        end
    end

    assign locked_out[0] = lock_held & lock_owner;
    assign locked_out[1] = lock_held & ~lock_owner;
`else
    assign locked_out = 2'b00;
`endif

    always_comb begin
        cls0 = classify(bus.req0_insn);
        cls1 = classify(bus.req1_insn);
        res0 = (cls0 == CLS_COMPUTE) || (cls0 == CLS_CCFG);
        res1 = (cls1 == CLS_COMPUTE) || (cls1 == CLS_CCFG);

        elig[0] = bus.req0_valid & ~(res0 & outstanding[0]) & ~locked_out[0] & ~reset;
        elig[1] = bus.req1_valid & ~(res1 & outstanding[1]) & ~locked_out[1] & ~reset;

        grant = 2'b00;
        if (elig[0] && elig[1]) begin
            grant[rr_ptr] = 1'b1;
        end else begin
            grant = elig;
        end
        granted  = |grant;
        grant_id = grant[1];

        sel_cls      = grant_id ? cls1              : cls0;
        sel_res      = grant_id ? res1              : res0;
        sel_insn     = grant_id ? bus.req1_insn     : bus.req0_insn;
        sel_rs1_real = grant_id ? bus.req1_rs1_real : bus.req0_rs1_real;
        sel_rs1_imag = grant_id ? bus.req1_rs1_imag : bus.req0_rs1_imag;
        sel_rs2      = grant_id ? bus.req1_rs2      : bus.req0_rs2;
        issue        = granted && (sel_cls != CLS_ILLEGAL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr          <= 1'b0;
            scie_valid_q    <= 1'b0;
            scie_insn_q     <= '0;
            scie_rs1_real_q <= '0;
            scie_rs1_imag_q <= '0;
            scie_rs2_q      <= '0;
            issue_id_q      <= 1'b0;
            issue_res_q     <= 1'b0;
            tag_valid       <= '0;
            tag_id          <= '0;
            tag_res         <= '0;
            resp_valid_q    <= 2'b00;
            resp0_real_q    <= '0;
            resp0_imag_q    <= '0;
            resp1_real_q    <= '0;
            resp1_imag_q    <= '0;
            err_illegal_q   <= 1'b0;
        end else begin
            scie_valid_q <= issue;
            if (issue) begin
                scie_insn_q     <= sel_insn;
                scie_rs1_real_q <= sel_rs1_real;
                scie_rs1_imag_q <= sel_rs1_imag;
                scie_rs2_q      <= sel_rs2;
                issue_id_q      <= grant_id;
                issue_res_q     <= sel_res;
            end
            if (granted) begin
                rr_ptr <= ~grant_id;
            end
            if (granted && sel_cls == CLS_ILLEGAL) begin
                err_illegal_q <= 1'b1;
            end

            tag_valid <= tag_valid_ext[LATENCY-1:0];
            tag_id    <= tag_id_ext[LATENCY-1:0];
            tag_res   <= tag_res_ext[LATENCY-1:0];

            // Steer the tail result into its requester's held response register
            if (tail_hit && !tail_id) begin
                resp_valid_q[0] <= 1'b1;
                resp0_real_q    <= bus.scie_rd_real;
                resp0_imag_q    <= bus.scie_rd_imag;
            end else if (resp_valid_q[0] && bus.resp0_ready) begin
                resp_valid_q[0] <= 1'b0;
            end
            if (tail_hit && tail_id) begin
                resp_valid_q[1] <= 1'b1;
                resp1_real_q    <= bus.scie_rd_real;
                resp1_imag_q    <= bus.scie_rd_imag;
            end else if (resp_valid_q[1] && bus.resp1_ready) begin
                resp_valid_q[1] <= 1'b0;
            end
        end
    end

    assign bus.req0_ready    = grant[0];
    assign bus.req1_ready    = grant[1];
    assign bus.scie_valid    = scie_valid_q;
    assign bus.scie_insn     = scie_insn_q;
    assign bus.scie_rs1_real = scie_rs1_real_q;
    assign bus.scie_rs1_imag = scie_rs1_imag_q;
    assign bus.scie_rs2      = scie_rs2_q;
    assign bus.resp0_valid   = resp_valid_q[0];
    assign bus.resp0_real    = resp0_real_q;
    assign bus.resp0_imag    = resp0_imag_q;
    assign bus.resp1_valid   = resp_valid_q[1];
    assign bus.resp1_real    = resp1_real_q;
    assign bus.resp1_imag    = resp1_imag_q;
    assign bus.err_illegal   = err_illegal_q;
endmodule
